// File: rtl/ray_aabb_slab_test_if.sv
// Ray/box slab-test bus: ray and box in on one valid/ready channel, hit/t_near/t_far out on another.
// Both channels: a transfer happens on a rising clk edge where valid && ready; the source holds its payload stable while valid && !ready.
interface ray_aabb_slab_test_if #(
    parameter int WIDTH = 16
);
    logic               in_valid;
    logic               in_ready;
    logic               skip_in;
    logic [3*WIDTH-1:0] inv_dir;
    logic [3*WIDTH-1:0] origin;
    logic [3*WIDTH-1:0] box_min;
    logic [3*WIDTH-1:0] box_max;
    logic [WIDTH-1:0]   t_max;
    logic               out_valid;
    logic               out_ready;
    logic               hit;
    logic [WIDTH-1:0]   t_near;
    logic [WIDTH-1:0]   t_far;
    logic               skip_out;

    modport slave (
        input  in_valid, skip_in, inv_dir, origin, box_min, box_max, t_max, out_ready,
        output in_ready, out_valid, hit, t_near, t_far, skip_out
    );

    modport master (
        output in_valid, skip_in, inv_dir, origin, box_min, box_max, t_max, out_ready,
        input  in_ready, out_valid, hit, t_near, t_far, skip_out
    );
endinterface

// File: rtl/ray_aabb_slab_test.sv
// Four-stage ray vs AABB slab test (subtract, scale+saturate, order, reduce) for BVH traversal.
// Vectors pack {x,y,z} with x in the top WIDTH bits; all values are signed Q3.12.
module ray_aabb_slab_test #(
    parameter int WIDTH  = 16,
    parameter int Q_BITS = 12
) (
    input logic                 clk,
    input logic                 reset,
    ray_aabb_slab_test_if.slave bus
);
    localparam int PW = 2*WIDTH + 1;
    localparam logic signed [PW-1:0] SAT_HI = {{(WIDTH+2){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_LO = {{(WIDTH+2){1'b1}}, {(WIDTH-1){1'b0}}};

    logic w_advance;
    logic r_v1, r_v2, r_v3, r_v4;

    logic signed [WIDTH:0]   w_d_lo [3];
    logic signed [WIDTH:0]   w_d_hi [3];
    logic signed [WIDTH:0]   r_d_lo [3];
    logic signed [WIDTH:0]   r_d_hi [3];
    logic signed [WIDTH-1:0] r_inv1 [3];
    logic signed [WIDTH-1:0] r_t_lo [3];
    logic signed [WIDTH-1:0] r_t_hi [3];
    logic signed [WIDTH-1:0] r_t0   [3];
    logic signed [WIDTH-1:0] r_t1   [3];
    logic signed [WIDTH-1:0] r_tmax1, r_tmax2, r_tmax3;
    logic                    r_skip1, r_skip2, r_skip3;

    logic signed [WIDTH-1:0] w_near, w_far;
    logic                    w_hit;

    logic                    r_hit;
    logic signed [WIDTH-1:0] r_t_near, r_t_far;
    logic                    r_skip_out;

    function automatic logic signed [WIDTH:0] sub_ext(input logic [WIDTH-1:0] a,
                                                      input logic [WIDTH-1:0] b);
        return $signed({a[WIDTH-1], a}) - $signed({b[WIDTH-1], b});
    endfunction

    // Arithmetic shift floors the product; a saturated inv_dir (divide-by-zero) times d=0 still gives 0.
    function automatic logic signed [WIDTH-1:0] scale_sat(input logic signed [WIDTH:0]   d,
                                                          input logic signed [WIDTH-1:0] inv);
        logic signed [PW-1:0] p;
        p = $signed({{WIDTH{d[WIDTH]}}, d}) * $signed({{(WIDTH+1){inv[WIDTH-1]}}, inv});
        p = p >>> Q_BITS;
        if (p > SAT_HI) begin
            return SAT_HI[WIDTH-1:0];
        end else if (p < SAT_LO) begin
            return SAT_LO[WIDTH-1:0];
        end
        return p[WIDTH-1:0];
    endfunction

    // Whole pipe moves together; a full output register that is not taken freezes every stage.
    assign w_advance    = !r_v4 || bus.out_ready;
    assign bus.in_ready = w_advance;

    always_comb begin
        for (int a = 0; a < 3; a++) begin
            w_d_lo[a] = sub_ext(bus.box_min[a*WIDTH +: WIDTH], bus.origin[a*WIDTH +: WIDTH]);
            w_d_hi[a] = sub_ext(bus.box_max[a*WIDTH +: WIDTH], bus.origin[a*WIDTH +: WIDTH]);
        end
    end

    always_comb begin
        w_near = r_t0[0];
        w_far  = r_t1[0];
        for (int a = 1; a < 3; a++) begin
            if (r_t0[a] > w_near) w_near = r_t0[a];
            if (r_t1[a] < w_far)  w_far  = r_t1[a];
        end
        w_hit = !r_skip3 && (w_near <= w_far) && !w_far[WIDTH-1] && (w_near <= r_tmax3);
    end

    // Datapath registers carry don't-care contents while their stage valid is low.
    always_ff @(posedge clk) begin
        if (w_advance) begin
            for (int a = 0; a < 3; a++) begin
                r_d_lo[a] <= w_d_lo[a];
                r_d_hi[a] <= w_d_hi[a];
                r_inv1[a] <= bus.inv_dir[a*WIDTH +: WIDTH];
                r_t_lo[a] <= scale_sat(r_d_lo[a], r_inv1[a]);
                r_t_hi[a] <= scale_sat(r_d_hi[a], r_inv1[a]);
                r_t0[a]   <= (r_t_lo[a] <= r_t_hi[a]) ? r_t_lo[a] : r_t_hi[a];
                r_t1[a]   <= (r_t_lo[a] <= r_t_hi[a]) ? r_t_hi[a] : r_t_lo[a];
            end
            r_tmax1 <= bus.t_max;
            r_tmax2 <= r_tmax1;
            r_tmax3 <= r_tmax2;
            r_skip1 <= bus.skip_in;
            r_skip2 <= r_skip1;
            r_skip3 <= r_skip2;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_v1       <= 1'b0;
            r_v2       <= 1'b0;
            r_v3       <= 1'b0;
            r_v4       <= 1'b0;
            r_hit      <= 1'b0;
            r_t_near   <= '0;
            r_t_far    <= '0;
            r_skip_out <= 1'b0;
        end else if (w_advance) begin
            r_v1       <= bus.in_valid;
            r_v2       <= r_v1;
            r_v3       <= r_v2;
            r_v4       <= r_v3;
            r_hit      <= r_v3 && w_hit;
            r_t_near   <= r_v3 ? w_near : '0;
            r_t_far    <= r_v3 ? w_far : '0;
            r_skip_out <= r_v3 && r_skip3;
        end
    end

    assign bus.out_valid = r_v4;
    assign bus.hit       = r_hit;
    assign bus.t_near    = r_t_near;
    assign bus.t_far     = r_t_far;
    assign bus.skip_out  = r_skip_out;
endmodule

// File: tb/tb_ray_aabb_slab_test.sv
// Bench for ray_aabb_slab_test: directed slab cases plus random streams checked against an integer reference model.
module tb_ray_aabb_slab_test;
  localparam int W  = 16;
  localparam int RW = 2 + 2*W;

  typedef struct packed {
    logic [2:0][W-1:0] inv;
    logic [2:0][W-1:0] org;
    logic [2:0][W-1:0] bmin;
    logic [2:0][W-1:0] bmax;
    logic [W-1:0]      tmax;
    logic              skip;
  } ray_t;

  logic clk = 1'b0;
  logic reset;
  logic [RW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ray_aabb_slab_test_if #(.WIDTH(W)) bus();

  ray_aabb_slab_test #(.WIDTH(W), .Q_BITS(12)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- reference model ----------------
  function automatic longint sat16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // result packing: {hit, skip, t_near, t_far}
  function automatic logic [RW-1:0] model(input ray_t r);
    longint tn, tf, o, lo, hi, t0, t1, tm;
    logic h;
    logic [W-1:0] tn16, tf16;
    tn = -1000000;
    tf = 1000000;
    for (int a = 0; a < 3; a++) begin
      o  = longint'($signed(r.org[a]));
      lo = sat16(((longint'($signed(r.bmin[a])) - o) * longint'($signed(r.inv[a]))) >>> 12);
      hi = sat16(((longint'($signed(r.bmax[a])) - o) * longint'($signed(r.inv[a]))) >>> 12);
      t0 = (lo < hi) ? lo : hi;
      t1 = (lo < hi) ? hi : lo;
      if (t0 > tn) tn = t0;
      if (t1 < tf) tf = t1;
    end
    tm = longint'($signed(r.tmax));
    h = !r.skip && (tn <= tf) && (tf >= 0) && (tn <= tm);
    tn16 = tn[W-1:0];
    tf16 = tf[W-1:0];
    return {h, r.skip, tn16, tf16};
  endfunction

  function automatic ray_t base_hit_ray();
    ray_t r;
    for (int a = 0; a < 3; a++) begin
      r.inv[a]  = 16'h1000;
      r.org[a]  = 16'h0000;
      r.bmin[a] = 16'h0800;
      r.bmax[a] = 16'h1000;
    end
    r.tmax = 16'h7FFF;
    r.skip = 1'b0;
    return r;
  endfunction

  function automatic ray_t rand_ray();
    ray_t r;
    int o, lo, span, iv, sel;
    for (int a = 0; a < 3; a++) begin
      o    = $urandom_range(0, 8192) - 4096;
      lo   = o + $urandom_range(0, 8192) - 4096;
      span = $urandom_range(0, 8192);
      sel  = $urandom_range(0, 9);
      if (sel == 0)      iv = 32767;
      else if (sel == 1) iv = -32768;
      else               iv = $urandom_range(0, 24576) - 12288;
      r.org[a]  = o[W-1:0];
      r.bmin[a] = lo[W-1:0];
      r.bmax[a] = 16'(lo + span);
      r.inv[a]  = iv[W-1:0];
    end
    r.tmax = 16'($urandom_range(0, 32767));
    r.skip = ($urandom_range(0, 7) == 0);
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    bus.in_valid = 1'b0;
    bus.skip_in  = 1'b0;
    bus.inv_dir  = '0;
    bus.origin   = '0;
    bus.box_min  = '0;
    bus.box_max  = '0;
    bus.t_max    = '0;
  endtask

  task automatic apply(input ray_t r);
    bus.in_valid = 1'b1;
    bus.inv_dir  = r.inv;
    bus.origin   = r.org;
    bus.box_min  = r.bmin;
    bus.box_max  = r.bmax;
    bus.t_max    = r.tmax;
    bus.skip_in  = r.skip;
  endtask

  function automatic logic [RW-1:0] observed();
    return {bus.hit, bus.skip_out, bus.t_near, bus.t_far};
  endfunction

  // Presents one ray with out_ready high; reports the cycle count at which out_valid first rose (0 = never).
  task automatic send_one(input ray_t r, output int lat, output logic [RW-1:0] obs);
    @(negedge clk);
    apply(r);
    bus.out_ready = 1'b1;
    lat = 0;
    obs = '0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) drive_idle();
      if (bus.out_valid === 1'b1 && lat == 0) begin
        lat = k;
        obs = observed();
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    bus.out_ready = 1'b0;
    apply(base_hit_ray());
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || observed() !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b res=%h expected valid=0 res=0", bus.out_valid, observed());
    end
    reset = 1'b0;
    drive_idle();
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: got in_ready=%b out_valid=%b expected 1/0", bus.in_ready, bus.out_valid);
    end
    bus.out_ready = 1'b1;
  endtask

  task automatic test_hit();
    int lat;
    logic [RW-1:0] obs;
    ray_t r = base_hit_ray();
    send_one(r, lat, obs);
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL hit_latency: got %0d expected 4", lat);
    end
    checks++;
    if (obs !== {1'b1, 1'b0, 16'h0800, 16'h1000}) begin
      errors++;
      $display("FAIL hit_result: got %h expected %h", obs, {1'b1, 1'b0, 16'h0800, 16'h1000});
    end
  endtask

  task automatic test_behind();
    int lat;
    logic [RW-1:0] obs;
    ray_t r = base_hit_ray();
    r.bmin[2] = 16'hE000;
    r.bmax[2] = 16'hF000;
    send_one(r, lat, obs);
    checks++;
    if (lat !== 4 || obs !== {1'b0, 1'b0, 16'h0800, 16'hF000} || obs !== model(r)) begin
      errors++;
      $display("FAIL behind_ray: got lat=%0d res=%h expected lat=4 res=%h", lat, obs, {1'b0, 1'b0, 16'h0800, 16'hF000});
    end
  endtask

  task automatic test_neg_dir();
    int lat;
    logic [RW-1:0] obs;
    ray_t r = base_hit_ray();
    r.inv[2]  = 16'hF000;
    r.bmin[2] = 16'hF000;
    r.bmax[2] = 16'hF800;
    send_one(r, lat, obs);
    checks++;
    if (lat !== 4 || obs !== {1'b1, 1'b0, 16'h0800, 16'h1000}) begin
      errors++;
      $display("FAIL neg_dir: got lat=%0d res=%h expected lat=4 res=%h", lat, obs, {1'b1, 1'b0, 16'h0800, 16'h1000});
    end
  endtask

  task automatic test_saturation();
    int lat;
    logic [RW-1:0] obs;
    ray_t r = base_hit_ray();
    // origin on the near face with a divide-by-zero inv_dir: 0 near, saturated far
    for (int a = 0; a < 3; a++) begin
      r.inv[a]  = 16'h7FFF;
      r.bmin[a] = 16'h0000;
      r.bmax[a] = (a == 0) ? 16'h4000 : 16'h1000;
    end
    send_one(r, lat, obs);
    checks++;
    if (lat !== 4 || obs !== {1'b1, 1'b0, 16'h0000, 16'h7FFF}) begin
      errors++;
      $display("FAIL sat_far: got lat=%0d res=%h expected lat=4 res=%h", lat, obs, {1'b1, 1'b0, 16'h0000, 16'h7FFF});
    end
    r = base_hit_ray();
    r.tmax = 16'h0400;
    send_one(r, lat, obs);
    checks++;
    if (obs !== {1'b0, 1'b0, 16'h0800, 16'h1000}) begin
      errors++;
      $display("FAIL tmax_cut: got %h expected %h", obs, {1'b0, 1'b0, 16'h0800, 16'h1000});
    end
    r.tmax = 16'h0800;
    send_one(r, lat, obs);
    checks++;
    if (obs !== {1'b1, 1'b0, 16'h0800, 16'h1000}) begin
      errors++;
      $display("FAIL tmax_inclusive: got %h expected %h", obs, {1'b1, 1'b0, 16'h0800, 16'h1000});
    end
    r = base_hit_ray();
    r.bmin[2] = 16'h1000;
    send_one(r, lat, obs);
    checks++;
    if (obs !== {1'b1, 1'b0, 16'h1000, 16'h1000}) begin
      errors++;
      $display("FAIL grazing: got %h expected %h", obs, {1'b1, 1'b0, 16'h1000, 16'h1000});
    end
  endtask

  task automatic test_skip();
    int lat;
    logic [RW-1:0] obs;
    ray_t r = base_hit_ray();
    r.skip = 1'b1;
    send_one(r, lat, obs);
    checks++;
    if (lat !== 4 || obs !== {1'b0, 1'b1, 16'h0800, 16'h1000}) begin
      errors++;
      $display("FAIL skip: got lat=%0d res=%h expected lat=4 res=%h", lat, obs, {1'b0, 1'b1, 16'h0800, 16'h1000});
    end
  endtask

  // mode 0: six back-to-back rays with out_ready low in cycles 5-7; mode 1: random gaps and random out_ready
  task automatic test_stream(input int n, input int mode);
    ray_t rq[$];
    logic [RW-1:0] obs, held, e;
    bit held_v, do_in;
    int sent, got, cyc;
    exp_q.delete();
    for (int i = 0; i < n; i++) rq.push_back(rand_ray());
    sent = 0; got = 0; cyc = 0; held_v = 0; held = '0;
    while (got < n && cyc < 600) begin
      @(negedge clk);
      if (sent < n && (mode == 0 || $urandom_range(0, 3) != 0)) apply(rq[sent]);
      else drive_idle();
      bus.out_ready = (mode == 0) ? !(cyc >= 5 && cyc <= 7) : ($urandom_range(0, 2) != 0);
      #1;
      obs = observed();
      if (held_v) begin
        checks++;
        if (bus.out_valid !== 1'b1 || obs !== held) begin
          errors++;
          $display("FAIL stall_hold: got valid=%b res=%h expected valid=1 res=%h", bus.out_valid, obs, held);
        end
      end
      if (mode == 0 && cyc >= 5 && cyc <= 7) begin
        checks++;
        if (bus.in_ready !== 1'b0) begin
          errors++;
          $display("FAIL stall_in_ready: cycle %0d got %b expected 0", cyc, bus.in_ready);
        end
      end
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL stream_extra: got res=%h expected no output", obs);
        end else begin
          e = exp_q.pop_front();
          if (obs !== e) begin
            errors++;
            $display("FAIL stream_result: item %0d got %h expected %h", got, obs, e);
          end
        end
        got++;
      end
      held_v = (bus.out_valid === 1'b1) && !bus.out_ready;
      held   = obs;
      do_in  = (bus.in_valid === 1'b1) && (bus.in_ready === 1'b1);
      @(posedge clk);
      if (do_in) begin
        exp_q.push_back(model(rq[sent]));
        sent++;
      end
      cyc++;
    end
    @(negedge clk);
    drive_idle();
    bus.out_ready = 1'b1;
    checks++;
    if (got != n || sent != n || exp_q.size() != 0) begin
      errors++;
      $display("FAIL stream_count: got %0d of %0d results (sent %0d, pending %0d) within %0d cycles", got, n, sent, exp_q.size(), cyc);
    end
  endtask

  task automatic test_reset_midflight();
    int lat, stale;
    logic [RW-1:0] obs;
    ray_t r = base_hit_ray();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      apply(r);
    end
    @(negedge clk);
    drive_idle();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || observed() !== '0) begin
      errors++;
      $display("FAIL reset_flush: got valid=%b res=%h expected valid=0 res=0", bus.out_valid, observed());
    end
    stale = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) stale++;
    end
    checks++;
    if (stale != 0) begin
      errors++;
      $display("FAIL reset_stale: got %0d stale outputs expected 0", stale);
    end
    send_one(r, lat, obs);
    checks++;
    if (lat !== 4 || obs !== model(r)) begin
      errors++;
      $display("FAIL post_reset: got lat=%0d res=%h expected lat=4 res=%h", lat, obs, model(r));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    drive_idle();
    bus.out_ready = 1'b1;
    test_reset();
    test_hit();
    test_behind();
    test_neg_dir();
    test_saturation();
    test_skip();
    test_stream(6, 0);
    test_stream(60, 1);
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
